dma_rr_arbiter: RTL and testbench
=================================

Name: dma_rr_arbiter

Overview:
- Round-robin arbiter that shares one ROM-read / RAM-write memory port among NUM_CH DMA channel engines.
- Each channel presents a beat stream (valid/ready, address, data, last flag). The arbiter grants the port to one channel at a time, for at most MAX_BEATS beats.
- Sits between the per-channel DMA controllers and the single memory interface.
- Guarantees fair access and bounded latency per channel.

Parameters:
- NUM_CH, 4, number of requesting channels (2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MAX_BEATS, 16, maximum beats per grant before forced release (power of 2, >=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ch_valid  in  NUM_CH  per-channel beat request.
- ch_addr  in  NUM_CH*ADDR_W  per-channel beat address, packed; channel i at [i*ADDR_W +: ADDR_W].
- ch_wdata  in  NUM_CH*DATA_W  per-channel write data, packed the same way.
- ch_last  in  NUM_CH  final beat of the channel's current transfer.
- ch_ready  out  NUM_CH  beat accepted; one-hot or zero.
- mem_valid  out  1  beat valid toward the memory port.
- mem_addr  out  ADDR_W  granted channel address.
- mem_wdata  out  DATA_W  granted channel data.
- mem_ready  in  1  memory accepts beat.
- grant_valid  out  1  a channel currently owns the port.
- grant_id  out  $clog2(NUM_CH)  owning channel index.

Behaviour:
- Reset: all registered state clears.
  - State = IDLE, grant_valid=0, grant_id=0, beat_cnt=0.
  - last_id=NUM_CH-1, so channel 0 wins the first arbitration.
  - mem_valid=0, ch_ready=0, mem_addr=0, mem_wdata=0.
- States: IDLE, OWN.
- IDLE:
  - If any ch_valid is high, pick the first requester searching from (last_id+1) mod NUM_CH upward with wrap.
  - Register the pick into grant_id, set grant_valid=1 and beat_cnt=0, and go to OWN.
  - Arbitration latency is one cycle: the request is seen in cycle N, the grant is visible in cycle N+1.
  - No ch_ready is asserted in IDLE.
- OWN, datapath:
  - mem_valid = ch_valid[grant_id].
  - mem_addr and mem_wdata are muxed combinationally from grant_id.
  - ch_ready[grant_id] = mem_ready. All other ch_ready bits are 0.
  - A beat completes when mem_valid && mem_ready; beat_cnt then increments.
- OWN, release conditions (checked on a completed beat):
  - ch_last[grant_id]=1, or
  - beat_cnt == MAX_BEATS-1.
- OWN, other release:
  - ch_valid[grant_id] low for a cycle in OWN is a voluntary release; no beat is transferred that cycle.
- On release:
  - last_id <= grant_id, grant_valid <= 0, state <= IDLE.
  - The next cycle is a mandatory one-cycle arbitration gap.
- Fairness:
  - A channel requesting continuously waits at most (NUM_CH-1)*(MAX_BEATS+1) cycles plus memory stall cycles.
  - A released channel has the lowest priority in the next arbitration.
- Simultaneous events: a channel asserting ch_valid in the same cycle another releases is considered in the next IDLE cycle.
- mem_ready stall: a held beat (mem_valid=1, mem_ready=0) does not increment beat_cnt and does not release.
- IDLE outputs: mem_addr and mem_wdata drive 0, mem_valid=0.
- Reset mid-grant: aborts immediately to the reset values. Channels must re-request.
- beat_cnt width: $clog2(MAX_BEATS)+1. It never wraps, because release occurs first.

Decomposition:
- Package dma_arb_pkg:
  - arb_state_t enum {IDLE, OWN}.
  - localparam CH_ID_W function of NUM_CH.
- Sub-module dma_rr_pick: purely combinational round-robin picker.
  - Inputs: req[NUM_CH], last_id.
  - Outputs: pick_valid, pick_id.
  - Built with a double-width rotate-and-priority-encode.
- Top level holds the FSM, counter and datapath muxes.

Test Plan:
1. After reset, ch_valid=4'b1111 held, mem_ready=1, ch_last=0 -> grants in order 0,1,2,3,0.
   - Each grant spans exactly 16 beats.
   - Each grant is followed by one cycle with grant_valid=0.
2. Only ch2 valid, ch_last asserted on its 3rd beat, mem_ready=1 -> grant_id=2 for 3 beats; grant_valid drops the cycle after beat 3; ch_ready[2] pulses exactly 3 times.
3. ch1 owns the port, mem_ready=0 for 5 cycles then 1 -> mem_valid held, mem_addr stable at ch1 address, beat_cnt unchanged during the stall, no release.
4. ch0 and ch3 request together after ch3 just released -> ch0 is granted first (ch3 is lowest priority).
5. ch1 owns with beat_cnt=7 and asserts reset -> next cycle all outputs are 0 and grant_valid=0. After reset deasserts with ch1 valid, ch1 is granted with beat_cnt=0.
6. ch2 granted, then ch_valid[2] drops with no beat -> release; last_id=2; pending ch3 is granted 2 cycles later.

Source files
------------

// File: rtl/dma_arb_pkg.sv
// Shared types and sizing helpers for the DMA round-robin memory-port arbiter.
package dma_arb_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StOwn
  } arb_state_t;

  // Channel index width; a single channel still needs one bit.
  function automatic int unsigned ch_id_w(input int unsigned num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  localparam int unsigned DefaultNumCh = 4;
  localparam int unsigned ChIdW        = ch_id_w(DefaultNumCh);

endpackage

// File: rtl/dma_rr_pick.sv
// Combinational round-robin picker: first requester at or after last_id+1, with wrap.
module dma_rr_pick #(
  parameter int unsigned NumCh = 4,
  parameter int unsigned IdW   = 2
) (
  input  logic [NumCh-1:0] req_i,
  input  logic [IdW-1:0]   last_id_i,
  output logic             pick_valid_o,
  output logic [IdW-1:0]   pick_id_o
);

  logic [2*NumCh-1:0] req_dbl;
  logic [NumCh-1:0]   req_rot;
  int unsigned        start;
  int unsigned        offset;
  logic               found;

  always_comb begin
    start   = (32'(last_id_i) + 32'd1) % NumCh;
    // Doubling the request vector turns the rotate into a plain shift.
    req_dbl = {req_i, req_i};
    req_rot = NumCh'(req_dbl >> start);
    offset  = 0;
    found   = 1'b0;
    for (int unsigned i = 0; i < NumCh; i++) begin
      if (req_rot[i] && !found) begin
        found  = 1'b1;
        offset = i;
      end
    end
    pick_valid_o = |req_i;
    pick_id_o    = IdW'((start + offset) % NumCh);
  end

endmodule

// File: rtl/dma_rr_arbiter.sv
// Round-robin arbiter sharing one memory port among NumCh DMA beat streams,
// with a bounded burst length per grant and a one-cycle gap between grants.
module dma_rr_arbiter
  import dma_arb_pkg::*;
#(
  parameter  int unsigned NumCh    = 4,
  parameter  int unsigned AddrW    = 32,
  parameter  int unsigned DataW    = 32,
  parameter  int unsigned MaxBeats = 16,
  localparam int unsigned IdW      = ch_id_w(NumCh)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NumCh-1:0]       ch_valid_i,
  input  logic [NumCh*AddrW-1:0] ch_addr_i,
  input  logic [NumCh*DataW-1:0] ch_wdata_i,
  input  logic [NumCh-1:0]       ch_last_i,
  output logic [NumCh-1:0]       ch_ready_o,
  output logic                   mem_valid_o,
  output logic [AddrW-1:0]       mem_addr_o,
  output logic [DataW-1:0]       mem_wdata_o,
  input  logic                   mem_ready_i,
  output logic                   grant_valid_o,
  output logic [IdW-1:0]         grant_id_o
);

  localparam int unsigned CntW = $clog2(MaxBeats) + 1;

  arb_state_t      state_q;
  logic [IdW-1:0]  grant_id_q;
  logic [IdW-1:0]  last_id_q;
  logic            grant_valid_q;
  logic [CntW-1:0] beat_cnt_q;

  logic            pick_valid;
  logic [IdW-1:0]  pick_id;

  dma_rr_pick #(
    .NumCh(NumCh),
    .IdW  (IdW)
  ) u_pick (
    .req_i       (ch_valid_i),
    .last_id_i   (last_id_q),
    .pick_valid_o(pick_valid),
    .pick_id_o   (pick_id)
  );

  logic own;
  logic sel_valid;
  logic sel_last;
  logic beat;
  logic cnt_max;
  logic release_now;

  always_comb begin
    own         = (state_q == StOwn);
    sel_valid   = ch_valid_i[grant_id_q];
    sel_last    = ch_last_i[grant_id_q];
    beat        = own && sel_valid && mem_ready_i;
    cnt_max     = (beat_cnt_q == CntW'(MaxBeats - 1));
    // A dropped request in OWN is a voluntary release with no transfer.
    release_now = own && (!sel_valid || (beat && (sel_last || cnt_max)));

    mem_valid_o = own && sel_valid;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    ch_ready_o  = '0;
    if (own) begin
      mem_addr_o             = AddrW'(ch_addr_i >> (32'(grant_id_q) * AddrW));
      mem_wdata_o            = DataW'(ch_wdata_i >> (32'(grant_id_q) * DataW));
      ch_ready_o[grant_id_q] = mem_ready_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      last_id_q     <= IdW'(NumCh - 1);
      beat_cnt_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pick_valid) begin
            grant_id_q    <= pick_id;
            grant_valid_q <= 1'b1;
            beat_cnt_q    <= '0;
            state_q       <= StOwn;
          end
        end
        StOwn: begin
          if (release_now) begin
            last_id_q     <= grant_id_q;
            grant_valid_q <= 1'b0;
            state_q       <= StIdle;
          end else if (beat) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign grant_valid_o = grant_valid_q;
  assign grant_id_o    = grant_id_q;

endmodule

// File: tb/tb_dma_rr_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
module tb_dma_rr_arbiter;

  localparam int NumCh    = 4;
  localparam int AddrW    = 32;
  localparam int DataW    = 32;
  localparam int MaxBeats = 16;
  localparam int IdW      = 2;

  logic                   clk_i = 1'b0;
  logic                   rst_i;
  logic [NumCh-1:0]       ch_valid;
  logic [NumCh-1:0]       ch_last;
  logic [NumCh-1:0]       ch_ready;
  logic [NumCh*AddrW-1:0] ch_addr;
  logic [NumCh*DataW-1:0] ch_wdata;
  logic                   mem_ready;
  logic                   mem_valid;
  logic [AddrW-1:0]       mem_addr;
  logic [DataW-1:0]       mem_wdata;
  logic                   grant_valid;
  logic [IdW-1:0]         grant_id;

  logic [AddrW-1:0] addr_a [NumCh];
  logic [DataW-1:0] data_a [NumCh];

  for (genvar g = 0; g < NumCh; g++) begin : g_pack
    assign ch_addr[g*AddrW +: AddrW]  = addr_a[g];
    assign ch_wdata[g*DataW +: DataW] = data_a[g];
  end

  always #5 clk_i = ~clk_i;

  dma_rr_arbiter #(
    .NumCh   (NumCh),
    .AddrW   (AddrW),
    .DataW   (DataW),
    .MaxBeats(MaxBeats)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .ch_valid_i   (ch_valid),
    .ch_addr_i    (ch_addr),
    .ch_wdata_i   (ch_wdata),
    .ch_last_i    (ch_last),
    .ch_ready_o   (ch_ready),
    .mem_valid_o  (mem_valid),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_ready_i  (mem_ready),
    .grant_valid_o(grant_valid),
    .grant_id_o   (grant_id)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // Behavioural model: who owns the port, who went last, beats completed this grant.
  bit m_own;
  int m_id, m_last, m_cnt;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_own  <= 1'b0;
      m_id   <= 0;
      m_last <= NumCh - 1;
      m_cnt  <= 0;
    end else if (!m_own) begin : arb
      int pick;
      pick = -1;
      for (int k = 1; k <= NumCh; k++) begin
        if (pick < 0 && ch_valid[(m_last + k) % NumCh]) pick = (m_last + k) % NumCh;
      end
      if (pick >= 0) begin
        m_own <= 1'b1;
        m_id  <= pick;
        m_cnt <= 0;
      end
    end else if (!ch_valid[m_id]) begin
      m_own  <= 1'b0;
      m_last <= m_id;
    end else if (mem_ready) begin
      if (ch_last[m_id] || (m_cnt + 1 == MaxBeats)) begin
        m_own  <= 1'b0;
        m_last <= m_id;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  always @(negedge clk_i) begin
    chk("grant_valid", grant_valid, m_own);
    chk("grant_id", grant_id, m_id);
    chk("mem_valid", mem_valid, m_own && ch_valid[m_id]);
    chk("mem_addr", mem_addr, m_own ? addr_a[m_id] : '0);
    chk("mem_wdata", mem_wdata, m_own ? data_a[m_id] : '0);
    chk("ch_ready", ch_ready, (m_own && mem_ready) ? (64'd1 << m_id) : 64'd0);
  end

  // Grant-level monitor used by the literal scenario checks.
  int grant_q[$];
  int beats_q[$];
  int gap_q[$];
  int rdy_cnt [NumCh];
  bit prev_gv;
  int cur_beats, gap;

  always @(negedge clk_i) begin
    if (rst_i) begin
      prev_gv   = 1'b0;
      cur_beats = 0;
      gap       = 0;
    end else begin
      if (grant_valid) begin
        if (!prev_gv) begin
          grant_q.push_back(int'(grant_id));
          gap_q.push_back(gap);
          cur_beats = 0;
        end
        if (mem_valid && mem_ready) cur_beats++;
      end else begin
        if (prev_gv) begin
          beats_q.push_back(cur_beats);
          gap = 0;
        end
        gap++;
      end
      for (int i = 0; i < NumCh; i++) if (ch_ready[i]) rdy_cnt[i]++;
      prev_gv = grant_valid;
    end
  end

  task automatic clear_mon();
    grant_q.delete();
    beats_q.delete();
    gap_q.delete();
    for (int i = 0; i < NumCh; i++) rdy_cnt[i] = 0;
  endtask

  // Drive one channel until it has moved its burst; optional last beat and stall window.
  task automatic drive_burst(input int ch, input int nlast, input int stall_at,
                             input int stall_len, input bit keep, output int n,
                             output int stalls);
    int  cyc;
    int  target;
    bit  own;
    n      = 0;
    stalls = 0;
    cyc    = 0;
    target = (nlast > 0) ? nlast : MaxBeats;
    ch_valid[ch] = 1'b1;
    while (n < target && cyc < 200) begin
      #1;
      own         = grant_valid && (int'(grant_id) == ch);
      ch_last[ch] = (nlast > 0) && (n == nlast - 1);
      mem_ready   = !(own && n == stall_at && stalls < stall_len);
      #1;
      if (own && !mem_ready) begin
        stalls++;
        chk("stall_mem_valid", mem_valid, 1'b1);
        chk("stall_mem_addr", mem_addr, addr_a[ch]);
      end
      if (ch_ready[ch]) n++;
      step();
      cyc++;
    end
    if (n < target) chk("burst_timeout", n, target);
    if (!keep) ch_valid[ch] = 1'b0;
    ch_last[ch] = 1'b0;
    mem_ready   = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int exp_order [5];
    int n, st, cyc;
    exp_order = '{0, 1, 2, 3, 0};
    rst_i     = 1'b1;
    ch_valid  = '0;
    ch_last   = '0;
    mem_ready = 1'b0;
    for (int i = 0; i < NumCh; i++) begin
      addr_a[i] = 32'hA000_0000 + 32'(i * 'h100);
      data_a[i] = 32'hD000_0000 + 32'(i);
    end
    step();
    step();
    chk("rst_grant_valid", grant_valid, 1'b0);
    chk("rst_mem_valid", mem_valid, 1'b0);
    chk("rst_ch_ready", ch_ready, '0);
    chk("rst_mem_addr", mem_addr, '0);
    clear_mon();

    // 1: all channels hungry -> 0,1,2,3,0, full 16-beat grants, one-cycle gaps.
    rst_i     = 1'b0;
    ch_valid  = 4'b1111;
    mem_ready = 1'b1;
    cyc = 0;
    while (grant_q.size() < 5 && cyc < 300) begin
      step();
      cyc++;
    end
    chk("t1_grants_seen", grant_q.size(), 5);
    for (int i = 0; i < 5; i++) chk($sformatf("t1_grant%0d", i), qat(grant_q, i), exp_order[i]);
    for (int i = 0; i < 4; i++) chk($sformatf("t1_beats%0d", i), qat(beats_q, i), MaxBeats);
    for (int i = 1; i < 5; i++) chk($sformatf("t1_gap%0d", i), qat(gap_q, i), 1);
    ch_valid = '0;
    repeat (3) step();

    // 2: ch2 alone, last on its third beat.
    clear_mon();
    drive_burst(2, 3, -1, 0, 1'b0, n, st);
    chk("t2_gv_after_last", grant_valid, 1'b0);
    repeat (3) step();
    chk("t2_grant", qat(grant_q, 0), 2);
    chk("t2_beats", qat(beats_q, 0), 3);
    chk("t2_ready_pulses", rdy_cnt[2], 3);

    // 3: ch1 stalled for 5 cycles after two beats; still gets exactly 16 beats.
    clear_mon();
    drive_burst(1, 0, 2, 5, 1'b0, n, st);
    chk("t3_stalls", st, 5);
    chk("t3_beats_drv", n, MaxBeats);
    repeat (2) step();
    chk("t3_grant", qat(grant_q, 0), 1);
    chk("t3_beats", qat(beats_q, 0), MaxBeats);
    chk("t3_grants_seen", grant_q.size(), 1);

    // 4: ch3 releases, then ch0 and ch3 both request -> ch0 wins.
    clear_mon();
    drive_burst(3, 2, -1, 0, 1'b1, n, st);
    ch_valid[0] = 1'b1;
    step();
    chk("t4_gv", grant_valid, 1'b1);
    chk("t4_grant_id", grant_id, 0);
    ch_valid = '0;
    repeat (3) step();

    // 5: reset in the middle of a ch1 grant after 7 beats.
    ch_valid[1] = 1'b1;
    mem_ready   = 1'b1;
    n   = 0;
    cyc = 0;
    while (n < 7 && cyc < 100) begin
      #1;
      if (ch_ready[1]) n++;
      step();
      cyc++;
    end
    chk("t5_pre_beats", n, 7);
    rst_i = 1'b1;
    #1;
    chk("t5_rst_gv", grant_valid, 1'b0);
    chk("t5_rst_mv", mem_valid, 1'b0);
    chk("t5_rst_ready", ch_ready, '0);
    chk("t5_rst_addr", mem_addr, '0);
    chk("t5_rst_wdata", mem_wdata, '0);
    step();
    step();
    clear_mon();
    rst_i = 1'b0;
    drive_burst(1, 0, -1, 0, 1'b0, n, st);
    repeat (2) step();
    chk("t5_grant", qat(grant_q, 0), 1);
    chk("t5_beats", qat(beats_q, 0), MaxBeats);

    // 6: ch2 granted, drops its request without a beat; pending ch3 follows.
    ch_valid[2] = 1'b1;
    mem_ready   = 1'b0;
    cyc = 0;
    while (!(grant_valid && grant_id == 2'd2) && cyc < 20) begin
      step();
      cyc++;
    end
    chk("t6_ch2_granted", grant_valid && grant_id == 2'd2, 1'b1);
    ch_valid = 4'b1000;
    step();
    chk("t6_gap_gv", grant_valid, 1'b0);
    step();
    chk("t6_gv", grant_valid, 1'b1);
    chk("t6_grant_id", grant_id, 3);
    ch_valid  = '0;
    mem_ready = 1'b1;
    repeat (3) step();

    // Random traffic checked cycle by cycle against the model.
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < NumCh; i++) begin
        ch_valid[i] = ($urandom_range(0, 9) != 0);
        ch_last[i]  = ($urandom_range(0, 11) == 0);
        addr_a[i]   = $urandom();
        data_a[i]   = $urandom();
      end
      mem_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
